logic_shift_unit: RTL and testbench
===================================

// Module: logic_shift_unit
// PURPOSE
//  N-bit registered logic/shift unit; parametrised successor of the 1-bit logic slice.
//  Executes AND/OR/XOR/NOT in one cycle and shift/rotate by a variable amount iteratively, one bit per cycle.
//  Sits beside the adder in the ALU datapath behind a valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH    8                operand/result width; power of two, >= 2
//  SHAMT_W  $clog2(WIDTH)    shift-amount width (derived; do not override)
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        reset: asynchronous assert, active-low
//  in_valid    in   1        request valid
//  in_ready    out  1        unit can accept a request
//  op1         in   WIDTH    operand A (shift/rotate source)
//  op2         in   WIDTH    operand B (logic ops only)
//  opsel       in   3        operation code, see BEHAVIOUR
//  shamt       in   SHAMT_W  shift/rotate amount
//  cin         in   1        fill bit for SHL/SHR
//  flush       in   1        synchronous abort, returns to IDLE
//  out_valid   out  1        result valid
//  out_ready   in   1        consumer accepts result
//  result      out  WIDTH    result
//  cout        out  1        last bit shifted/rotated out; 0 for logic ops
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, counter=0.
//  - opsel: 000 AND, 001 OR, 010 XOR, 011 NOT op1, 100 SHL, 101 SHR, 110 ROL, 111 ROR.
//  - FSM IDLE/SHIFT/DONE. in_ready=1 only in IDLE; accept = in_valid & in_ready.
//  - IDLE, accept, opsel[2]=0: result<=logic(op1,op2), cout<=0, -> DONE (latency 1).
//  - IDLE, accept, opsel[2]=1, shamt=0: result<=op1, cout<=0, -> DONE (latency 1).
//  - IDLE, accept, opsel[2]=1, shamt>0: load op1, cin, opsel, count<=shamt, -> SHIFT.
//  - SHIFT: one 1-bit step per cycle; count-1; cout<=bit leaving (MSB for SHL/ROL, LSB for SHR/ROR).
//    SHL/SHR fill with latched cin; ROL/ROR fill with bit leaving. count reaches 0 -> DONE.
//    Latency shamt+1 cycles from accept to out_valid. Inputs ignored after accept.
//  - DONE: out_valid=1; result/cout stable until out_valid & out_ready, then -> IDLE.
//    Next request can be accepted no earlier than the cycle after the handshake.
//  - flush=1 in any state: -> IDLE next edge, out_valid<=0, in_progress op discarded.
//    flush has priority over accept and over out_ready; result/cout retain last values.
//  - rst_n deassert mid-operation: op lost, no out_valid produced.
//  - All arithmetic modulo WIDTH; count is SHAMT_W bits, never wraps below 0.
// STRUCTURE
//  - Package logic_unit_pkg: typedef enum logic [2:0] opsel_e (OP_AND..OP_ROR),
//    typedef enum state_e {IDLE,SHIFT,DONE}, localparam default WIDTH.
//  - Sub-module shift_step: combinational 1-bit shift/rotate (data, dir, rotate, fill -> data, out_bit);
//    instantiated once; FSM, counter, and logic ops remain in the top.
// TESTING (WIDTH=8)
//  - Logic: op1=8'hF0, op2=8'h3C, opsel 000/001/010/011 -> 8'h30/8'hFC/8'hCC/8'h0F, cout=0, out_valid 1 cycle after accept.
//  - SHL: op1=8'h81, shamt=3, cin=1 -> result 8'h0F, cout=0, out_valid 4 cycles after accept; in_ready=0 meanwhile.
//  - ROR: op1=8'h01, shamt=1 -> 8'h80, cout=1; shamt=0 with any op -> result=op1, cout=0, latency 1.
//  - Backpressure: out_ready=0 for 5 cycles in DONE -> result/cout stable, in_ready=0; out_ready=1 -> IDLE next cycle.
//  - flush during SHIFT (shamt=7, cycle 3) -> IDLE next edge, no out_valid; next request completes normally.
//  - Async reset asserted mid-SHIFT -> outputs zero immediately without clock edge; in_ready=1 after release.

Source files
------------

// File: rtl/logic_unit_pkg.sv
`timescale 1ns/1ps
// Shared types for the logic/shift unit: operation codes, FSM states, default width.
package logic_unit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_ROL = 3'b110,
        OP_ROR = 3'b111
    } opsel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Shift/rotate ops have bit 2 set; bit 0 selects right, bit 1 selects rotate.
    function automatic logic is_shift_op(input opsel_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/shift_step.sv
`timescale 1ns/1ps
// One-bit shift/rotate step: moves data one position left or right.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Rotate feeds the departing bit back in; otherwise the fill bit enters.
module shift_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic             rotate,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out,
    output logic             out_bit
);

    logic in_bit;

    always_comb begin
        out_bit  = dir ? data[0] : data[WIDTH-1];
        in_bit   = rotate ? out_bit : fill;
        data_out = dir ? {in_bit, data[WIDTH-1:1]} : {data[WIDTH-2:0], in_bit};
    end

endmodule

// File: rtl/logic_shift_unit.sv
`timescale 1ns/1ps
// Registered N-bit logic/shift unit: AND/OR/XOR/NOT, iterative SHL/SHR/ROL/ROR.
// Latency: 1 cycle for logic ops and zero shifts, shamt+1 cycles for shifts.
// Backpressure: holds result in DONE until out_ready; accepts only when IDLE.
module logic_shift_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [2:0]         opsel,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               cin,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               cout
);

    state_e             state_q, state_d;
    opsel_e             op_in, op_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic [SHAMT_W-1:0] count_q;
    logic               fill_q;
    logic               accept;
    logic               start_shift;
    logic [WIDTH-1:0]   logic_res;
    logic [WIDTH-1:0]   step_data;
    logic               step_bit;

    assign op_in       = opsel_e'(opsel);
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign accept      = in_valid & in_ready;
    assign start_shift = is_shift_op(op_in) && (shamt != '0);
    assign result      = result_q;
    assign cout        = cout_q;

    always_comb begin
        logic_res = '0;
        case (op_in)
            OP_AND:  logic_res = op1 & op2;
            OP_OR:   logic_res = op1 | op2;
            OP_XOR:  logic_res = op1 ^ op2;
            OP_NOT:  logic_res = ~op1;
            default: logic_res = op1;
        endcase
    end

    // The result register doubles as the shift register during SHIFT.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .data     (result_q),
        .dir      (op_q[0]),
        .rotate   (op_q[1]),
        .fill     (fill_q),
        .data_out (step_data),
        .out_bit  (step_bit)
    );

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = start_shift ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (count_q == SHAMT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush leaves result/cout untouched; only the FSM is aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            count_q  <= '0;
            op_q     <= OP_AND;
            fill_q   <= 1'b0;
        end else if (!flush) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cout_q <= 1'b0;
                        op_q   <= op_in;
                        fill_q <= cin;
                        if (start_shift) begin
                            result_q <= op1;
                            count_q  <= shamt;
                        end else if (is_shift_op(op_in)) begin
                            result_q <= op1;
                        end else begin
                            result_q <= logic_res;
                        end
                    end
                end
                SHIFT: begin
                    result_q <= step_data;
                    cout_q   <= step_bit;
                    count_q  <= count_q - SHAMT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_shift_unit.sv
`timescale 1ns/1ps
// Self-checking bench for logic_shift_unit (WIDTH=8): directed table, corner sequences, random vs model.
module tb_logic_shift_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op1 = '0;
    logic [7:0] op2 = '0;
    logic [2:0] opsel = '0;
    logic [2:0] shamt = '0;
    logic       cin = 1'b0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       cout;

    int checks = 0;
    int errors = 0;

    logic_shift_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .opsel     (opsel),
        .shamt     (shamt),
        .cin       (cin),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [2:0] n;
        logic       c;
        logic [7:0] exp_res;
        logic       exp_cout;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the op's definition, not bit-serial steps.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                  input logic [2:0] n, input logic c,
                                  output logic [7:0] r, output logic co);
        int ai, ni, ones;
        ai = int'(a);
        ni = int'(n);
        ones = (1 << ni) - 1;
        co = 1'b0;
        r  = a;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a ^ b;
            3'b011: r = ~a;
            default: begin
                if (ni != 0) begin
                    case (op)
                        3'b100: begin r = 8'((ai << ni) | (c ? ones : 0));              co = a[8-ni]; end
                        3'b101: begin r = 8'((ai >> ni) | (c ? (ones << (8-ni)) : 0));  co = a[ni-1]; end
                        3'b110: begin r = 8'((ai << ni) | (ai >> (8-ni)));              co = a[8-ni]; end
                        default: begin r = 8'((ai >> ni) | (ai << (8-ni)));             co = a[ni-1]; end
                    endcase
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [2:0] n, input logic c);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("issue_in_ready_timeout", in_ready, 1);
        op1 = a; op2 = b; opsel = op; shamt = n; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1 = 8'($urandom); op2 = 8'($urandom); opsel = 3'($urandom);
        shamt = 3'($urandom); cin = 1'($urandom);
    endtask

    // Returns cycles from accept to first out_valid; busy_ok clears if in_ready rose meanwhile.
    task automatic wait_valid(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 50);
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op, input logic [2:0] n, input logic c,
                                 input logic [7:0] exp_res, input logic exp_cout,
                                 input int exp_lat, input int hold);
        int lat;
        bit busy_ok;
        logic [7:0] r0;
        logic       c0;
        issue(a, b, op, n, c);
        wait_valid(lat, busy_ok);
        check({name, "_result"}, result, exp_res);
        check({name, "_cout"}, cout, exp_cout);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy"}, busy_ok, 1);
        r0 = result;
        c0 = cout;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!out_valid || in_ready || result !== r0 || cout !== c0)
                check({name, "_hold_stable"}, {out_valid, in_ready, cout, result}, {1'b1, 1'b0, c0, r0});
        end
        handshake();
    endtask

    initial begin
        bit seen;
        logic [7:0] mr;
        logic       mc;

        vecs[0] = '{8'hF0, 8'h3C, 3'b000, 3'd0, 1'b0, 8'h30, 1'b0, 1};
        vecs[1] = '{8'hF0, 8'h3C, 3'b001, 3'd5, 1'b1, 8'hFC, 1'b0, 1};
        vecs[2] = '{8'hF0, 8'h3C, 3'b010, 3'd0, 1'b0, 8'hCC, 1'b0, 1};
        vecs[3] = '{8'hF0, 8'h3C, 3'b011, 3'd2, 1'b0, 8'h0F, 1'b0, 1};
        vecs[4] = '{8'h81, 8'h00, 3'b100, 3'd3, 1'b1, 8'h0F, 1'b0, 4};
        vecs[5] = '{8'h01, 8'h00, 3'b111, 3'd1, 1'b0, 8'h80, 1'b1, 2};
        vecs[6] = '{8'hA5, 8'h00, 3'b101, 3'd0, 1'b1, 8'hA5, 1'b0, 1};
        vecs[7] = '{8'h96, 8'h00, 3'b101, 3'd2, 1'b0, 8'h25, 1'b1, 3};

        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_cout", cout, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].n,
                          vecs[i].c, vecs[i].exp_res, vecs[i].exp_cout, vecs[i].exp_lat, 0);
        end

        // Backpressure: result held five cycles, then IDLE right after the handshake.
        run_and_check("backpressure", 8'h96, 8'h00, 3'b101, 3'd2, 1'b0, 8'h25, 1'b1, 3, 5);
        @(negedge clk);
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);

        // Flush on the third shift cycle of a 7-step rotate.
        issue(8'h5A, 8'h00, 3'b110, 3'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_out_valid", seen, 0);
        run_and_check("after_flush", 8'h0F, 8'hFF, 3'b010, 3'd0, 1'b0, 8'hF0, 1'b0, 1, 0);

        // Asynchronous reset between clock edges mid-shift.
        issue(8'hFF, 8'h00, 3'b100, 3'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_result", result, 0);
        check("areset_cout", cout, 0);
        check("areset_out_valid", out_valid, 0);
        check("areset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("areset_no_out_valid", seen, 0);
        check("areset_in_ready_after", in_ready, 1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            logic [2:0] op, n;
            logic       c;
            int         lat;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 3'($urandom);
            n  = 3'($urandom);
            c  = 1'($urandom);
            model(a, b, op, n, c, mr, mc);
            lat = (op[2] && n != 0) ? int'(n) + 1 : 1;
            run_and_check($sformatf("rand%0d", i), a, b, op, n, c, mr, mc, lat,
                          int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
